// File: rtl/irq_sequencer.sv
// irq_sequencer: CP0-lite exception/interrupt sequencer for the 5-stage MIPS pipeline.
// Prioritises EX-stage overflow over external IRQ lines (bit 0 highest) and issues a
// one-cycle redirect+flush to INT_VECTOR. On ERET it issues a one-cycle redirect to EPC.
// Optional build macro IRQ_EDGE_EN: when defined, irq_in is synchronised and rising edges
// latch pending bits until taken; when undefined, pending follows irq_in directly (level).
module irq_sequencer #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [31:0] INT_VECTOR = 32'd356
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ovf_exc,
    input  logic [31:0]        ex_pc,
    input  logic               eret,
    input  logic               pipe_hold,
    input  logic               en_wr,
    input  logic [NUM_IRQ-1:0] en_din,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               flush_all,
    output logic               in_service,
    output logic [31:0]        epc,
    output logic [31:0]        cause
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [NUM_IRQ-1:0] enable_r;
    logic [NUM_IRQ-1:0] pending_s;
    logic [NUM_IRQ-1:0] masked_s;
    logic [7:0]         pend8_s;
    logic               take_s;
    logic               eret_go_s;
    logic               eret_pend_r;
    logic               redirect_r;
    logic [31:0]        redirect_pc_r;
    logic               in_service_r;
    logic [31:0]        epc_r;
    logic [31:0]        cause_r;

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] sync1_r;
    logic [NUM_IRQ-1:0] sync2_r;
    logic [NUM_IRQ-1:0] sync3_r;
    logic [NUM_IRQ-1:0] pending_r;
    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] clr_s;

    // One-hot of the lowest set bit (lowest index = highest priority).
    function automatic logic [NUM_IRQ-1:0] lowest_set(input logic [NUM_IRQ-1:0] vec);
        logic [NUM_IRQ-1:0] res;
        logic               found;
        res   = {NUM_IRQ{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            res[i] = vec[i] & ~found;
            found  = found | vec[i];
        end
        return res;
    endfunction

    // Rising-edge detect on the synchronised lines and the bit cleared when an IRQ is taken.
    always_comb begin
        rise_s = sync2_r & ~sync3_r;
        clr_s  = {NUM_IRQ{1'b0}};
        if (take_s && !ovf_exc) begin
            clr_s = lowest_set(masked_s);
        end else begin
            clr_s = {NUM_IRQ{1'b0}};
        end
    end

    // Two-flop synchroniser, edge history and sticky pending latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r   <= {NUM_IRQ{1'b0}};
            sync2_r   <= {NUM_IRQ{1'b0}};
            sync3_r   <= {NUM_IRQ{1'b0}};
            pending_r <= {NUM_IRQ{1'b0}};
        end else begin
            sync1_r   <= irq_in;
            sync2_r   <= sync1_r;
            sync3_r   <= sync2_r;
            pending_r <= (pending_r & ~clr_s) | rise_s;
        end
    end

    assign pending_s = pending_r;
`else
    // Level-sensitive: the source holds its line until serviced, so there is nothing to clear.
    assign pending_s = irq_in;
`endif

    assign masked_s = pending_s & enable_r;

    // Zero-extend the pending snapshot to the 8-bit Cause field.
    always_comb begin
        pend8_s                = 8'd0;
        pend8_s[NUM_IRQ-1:0]   = pending_s;
    end

    // Next-state logic; entry and return qualifiers are gated by pipe_hold.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        eret_go_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                take_s = (ovf_exc | (|masked_s)) & ~pipe_hold;
                if (take_s) begin
                    state_nxt_s = ST_TAKE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TAKE: begin
                state_nxt_s = ST_SERVICE;
            end
            ST_SERVICE: begin
                eret_go_s = (eret | eret_pend_r) & ~pipe_hold;
                if (eret_go_s) begin
                    state_nxt_s = ST_RETURN;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            ST_RETURN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Hold an ERET that arrived while the pipeline was stalled until the stall releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eret_pend_r <= 1'b0;
        end else if (state_r != ST_SERVICE || eret_go_s) begin
            eret_pend_r <= 1'b0;
        end else if (eret && pipe_hold) begin
            eret_pend_r <= 1'b1;
        end else begin
            eret_pend_r <= eret_pend_r;
        end
    end

    // Interrupt enable mask; a write is visible from the next cycle in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_r <= {NUM_IRQ{1'b1}};
        end else if (en_wr) begin
            enable_r <= en_din;
        end else begin
            enable_r <= enable_r;
        end
    end

    // EPC and Cause: snapshot on entry; nested overflow sets the sticky Cause[31].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_r   <= 32'd0;
            cause_r <= 32'd0;
        end else if (take_s) begin
            epc_r   <= ex_pc;
            cause_r <= {1'b0, 15'd0, pend8_s, 1'b0, (ovf_exc ? 5'd12 : 5'd0), 2'b00};
        end else if (state_r != ST_IDLE && ovf_exc) begin
            epc_r       <= epc_r;
            cause_r[31] <= 1'b1;
        end else begin
            epc_r   <= epc_r;
            cause_r <= cause_r;
        end
    end

    // Redirect/flush and in_service decoded from the next state so they align with TAKE/RETURN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'd0;
            in_service_r  <= 1'b0;
        end else begin
            case (state_nxt_s)
                ST_TAKE: begin
                    redirect_r    <= 1'b1;
                    redirect_pc_r <= INT_VECTOR;
                    in_service_r  <= 1'b0;
                end
                ST_RETURN: begin
                    redirect_r    <= 1'b1;
                    redirect_pc_r <= epc_r;
                    in_service_r  <= 1'b1;
                end
                ST_SERVICE: begin
                    redirect_r    <= 1'b0;
                    redirect_pc_r <= 32'd0;
                    in_service_r  <= 1'b1;
                end
                default: begin
                    redirect_r    <= 1'b0;
                    redirect_pc_r <= 32'd0;
                    in_service_r  <= 1'b0;
                end
            endcase
        end
    end

    assign redirect    = redirect_r;
    assign flush_all   = redirect_r;
    assign redirect_pc = redirect_pc_r;
    assign in_service  = in_service_r;
    assign epc         = epc_r;
    assign cause       = cause_r;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer (default level-sensitive build).
module tb_irq_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_in;
    logic        ovf_exc;
    logic [31:0] ex_pc;
    logic        eret;
    logic        pipe_hold;
    logic        en_wr;
    logic [7:0]  en_din;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_all;
    logic        in_service;
    logic [31:0] epc;
    logic [31:0] cause;

    int n_cmp;
    int n_bad;

    irq_sequencer #(.NUM_IRQ(8), .INT_VECTOR(32'd356)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .ovf_exc(ovf_exc), .ex_pc(ex_pc),
        .eret(eret), .pipe_hold(pipe_hold), .en_wr(en_wr), .en_din(en_din),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush_all(flush_all),
        .in_service(in_service), .epc(epc), .cause(cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Redirect/flush/pc triple checked together.
    task automatic chk_redir(input string tag, input logic r, input logic [31:0] pc);
        chk({tag, "_redirect"}, {31'd0, redirect}, {31'd0, r});
        chk({tag, "_flush"}, {31'd0, flush_all}, {31'd0, r});
        chk({tag, "_pc"}, redirect_pc, pc);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; irq_in = 8'd0; ovf_exc = 1'b0; ex_pc = 32'd0; eret = 1'b0;
        pipe_hold = 1'b0; en_wr = 1'b0; en_din = 8'd0;
        tick(); tick();
        // Reset state
        chk_redir("rst", 1'b0, 32'd0);
        chk("rst_insvc", {31'd0, in_service}, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_cause", cause, 32'd0);
        rst_n = 1'b1;
        tick();
        chk_redir("idle", 1'b0, 32'd0);

        // 1: overflow in IDLE
        ovf_exc = 1'b1; ex_pc = 32'h40;
        tick();
        chk_redir("t1_take", 1'b1, 32'd356);
        chk("t1_epc", epc, 32'h40);
        chk("t1_cause", cause, 32'h0000_0030);
        chk("t1_insvc_take", {31'd0, in_service}, 32'd0);
        ovf_exc = 1'b0; ex_pc = 32'd0;
        tick();
        chk_redir("t1_svc", 1'b0, 32'd0);
        chk("t1_insvc", {31'd0, in_service}, 32'd1);
        eret = 1'b1;
        tick();
        chk_redir("t1_ret", 1'b1, 32'h40);
        chk("t1_insvc_ret", {31'd0, in_service}, 32'd1);
        eret = 1'b0;
        tick();
        chk_redir("t1_idle", 1'b0, 32'd0);
        chk("t1_insvc_idle", {31'd0, in_service}, 32'd0);

        // eret in IDLE is ignored
        eret = 1'b1;
        tick();
        chk_redir("eret_idle", 1'b0, 32'd0);
        eret = 1'b0;

        // 2: two IRQs together; bit 1 wins, bit 2 follows after return
        irq_in = 8'b0000_0110; ex_pc = 32'h100;
        tick();
        chk_redir("t2_take1", 1'b1, 32'd356);
        chk("t2_epc1", epc, 32'h100);
        chk("t2_cause1", cause, 32'h0000_0600);
        irq_in = 8'b0000_0100;
        tick();
        chk_redir("t2_svc", 1'b0, 32'd0);
        eret = 1'b1;
        tick();
        chk_redir("t2_ret", 1'b1, 32'h100);
        eret = 1'b0; ex_pc = 32'h200;
        tick();
        chk_redir("t2_idle", 1'b0, 32'd0);
        tick();
        chk_redir("t2_take2", 1'b1, 32'd356);
        chk("t2_epc2", epc, 32'h200);
        chk("t2_cause2", cause, 32'h0000_0400);
        irq_in = 8'd0;
        tick();
        eret = 1'b1;
        tick();
        chk_redir("t2_ret2", 1'b1, 32'h200);
        eret = 1'b0;
        tick();

        // 3: overflow and irq0 together; overflow wins, irq0 right after
        ovf_exc = 1'b1; irq_in = 8'b0000_0001; ex_pc = 32'h300;
        tick();
        chk_redir("t3_take1", 1'b1, 32'd356);
        chk("t3_cause1", cause, 32'h0000_0130);
        chk("t3_epc1", epc, 32'h300);
        ovf_exc = 1'b0;
        tick();
        eret = 1'b1;
        tick();
        chk_redir("t3_ret", 1'b1, 32'h300);
        eret = 1'b0; ex_pc = 32'h304;
        tick();
        chk_redir("t3_idle", 1'b0, 32'd0);
        tick();
        chk_redir("t3_take2", 1'b1, 32'd356);
        chk("t3_cause2", cause, 32'h0000_0100);
        chk("t3_epc2", epc, 32'h304);
        irq_in = 8'd0;
        tick();
        chk("t3_insvc", {31'd0, in_service}, 32'd1);

        // 4: eret under 3 cycles of pipe_hold, nested overflow in SERVICE
        pipe_hold = 1'b1; eret = 1'b1;
        tick();
        chk_redir("t4_hold1", 1'b0, 32'd0);
        eret = 1'b0; ovf_exc = 1'b1;
        tick();
        chk_redir("t4_hold2", 1'b0, 32'd0);
        chk("t4_nested", cause, 32'h8000_0100);
        ovf_exc = 1'b0;
        tick();
        chk_redir("t4_hold3", 1'b0, 32'd0);
        pipe_hold = 1'b0;
        tick();
        chk_redir("t4_ret", 1'b1, 32'h304);
        chk("t4_cause_ret", cause, 32'h8000_0100);
        tick();
        chk_redir("t4_idle", 1'b0, 32'd0);
        chk("t4_insvc", {31'd0, in_service}, 32'd0);

        // Overflow while held in IDLE is dropped
        ovf_exc = 1'b1; pipe_hold = 1'b1;
        tick();
        chk_redir("ovf_held", 1'b0, 32'd0);
        ovf_exc = 1'b0; pipe_hold = 1'b0;
        tick();
        chk_redir("ovf_dropped", 1'b0, 32'd0);
        chk("ovf_dropped_cause", cause, 32'h8000_0100);

        // 5: masked IRQ, then enable
        en_wr = 1'b1; en_din = 8'h00;
        tick();
        en_wr = 1'b0; irq_in = 8'b0000_1000;
        tick();
        chk_redir("t5_mask1", 1'b0, 32'd0);
        tick();
        chk_redir("t5_mask2", 1'b0, 32'd0);
        en_wr = 1'b1; en_din = 8'hFF; ex_pc = 32'h500;
        tick();
        chk_redir("t5_enwr", 1'b0, 32'd0);
        en_wr = 1'b0;
        tick();
        chk_redir("t5_take", 1'b1, 32'd356);
        chk("t5_cause", cause, 32'h0000_0800);
        chk("t5_epc", epc, 32'h500);
        irq_in = 8'd0;
        tick();
        chk("t5_insvc", {31'd0, in_service}, 32'd1);

        // 6: reset in SERVICE
        rst_n = 1'b0;
        #1;
        chk("t6_insvc", {31'd0, in_service}, 32'd0);
        chk("t6_epc", epc, 32'd0);
        chk("t6_cause", cause, 32'd0);
        chk_redir("t6_async", 1'b0, 32'd0);
        tick();
        chk_redir("t6_held", 1'b0, 32'd0);
        rst_n = 1'b1;
        tick();
        chk_redir("t6_after", 1'b0, 32'd0);
        chk("t6_insvc2", {31'd0, in_service}, 32'd0);
        // Enable mask is back to all-ones: lowest-priority line is taken
        irq_in = 8'b1000_0000; ex_pc = 32'h600;
        tick();
        chk_redir("t6_take", 1'b1, 32'd356);
        chk("t6_cause2", cause, 32'h0000_8000);
        irq_in = 8'd0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
